// File: rtl/rx_block_sync_if.sv
// Gearbox-to-block-sync link: sync header with its qualifier in one direction,
// block lock and the bit-slip request in the other.
interface rx_block_sync_if #(
  parameter int HDR_WIDTH = 2
);
  logic [HDR_WIDTH-1:0] i_rx_hdr;
  logic                 i_rx_hdr_valid;
  logic                 o_block_lock;
  logic                 o_slip;

  modport master (
    output i_rx_hdr,
    output i_rx_hdr_valid,
    input  o_block_lock,
    input  o_slip
  );

  modport slave (
    input  i_rx_hdr,
    input  i_rx_hdr_valid,
    output o_block_lock,
    output o_slip
  );
endinterface

// File: rtl/rx_block_sync.sv
// 64b/66b block-lock state machine: counts good and bad sync headers per window,
// then either declares lock or asks the gearbox to slip one bit and re-test.
module rx_block_sync #(
  parameter int HDR_WIDTH      = 2,
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVALID_MAX = 16,
  parameter int SLIP_WAIT      = 8
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  rx_block_sync_if.slave  rx
);

  localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVALID_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  typedef enum logic [1:0] {
    ST_COUNT,
    ST_SLIP,
    ST_WAIT
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  sh_cnt, sh_cnt_n, sh_cnt_inc;
  logic [INV_W-1:0]  sh_inv_cnt, sh_inv_cnt_n, sh_inv_cnt_inc;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_n;
  logic              block_lock, block_lock_n;
  logic              slip, slip_n;
  logic              hdr_ok;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state      <= ST_COUNT;
      sh_cnt     <= '0;
      sh_inv_cnt <= '0;
      wait_cnt   <= '0;
      block_lock <= 1'b0;
      slip       <= 1'b0;
    end else begin
      state      <= state_n;
      sh_cnt     <= sh_cnt_n;
      sh_inv_cnt <= sh_inv_cnt_n;
      wait_cnt   <= wait_cnt_n;
      block_lock <= block_lock_n;
      slip       <= slip_n;
    end
  end

  always_comb begin
    state_n        = state;
    sh_cnt_n       = sh_cnt;
    sh_inv_cnt_n   = sh_inv_cnt;
    wait_cnt_n     = wait_cnt;
    block_lock_n   = block_lock;
    slip_n         = 1'b0;
    hdr_ok         = (rx.i_rx_hdr == HDR_WIDTH'(1)) || (rx.i_rx_hdr == HDR_WIDTH'(2));
    sh_cnt_inc     = sh_cnt + CNT_W'(1);
    sh_inv_cnt_inc = sh_inv_cnt + INV_W'(!hdr_ok);

    case (state)
      ST_COUNT: begin
        if (rx.i_rx_hdr_valid) begin
          sh_cnt_n     = sh_cnt_inc;
          sh_inv_cnt_n = sh_inv_cnt_inc;
          if (!block_lock) begin
            if (!hdr_ok) begin
              state_n      = ST_SLIP;
              slip_n       = 1'b1;
              sh_cnt_n     = '0;
              sh_inv_cnt_n = '0;
            end else if (sh_cnt_inc == CNT_W'(SH_CNT_MAX)) begin
              block_lock_n = 1'b1;
              sh_cnt_n     = '0;
              sh_inv_cnt_n = '0;
            end
          end else begin
            // Loss of lock is checked first so it wins on the last header of a window.
            if (!hdr_ok && (sh_inv_cnt_inc == INV_W'(SH_INVALID_MAX))) begin
              block_lock_n = 1'b0;
              state_n      = ST_SLIP;
              slip_n       = 1'b1;
              sh_cnt_n     = '0;
              sh_inv_cnt_n = '0;
            end else if (sh_cnt_inc == CNT_W'(SH_CNT_MAX)) begin
              sh_cnt_n     = '0;
              sh_inv_cnt_n = '0;
            end
          end
        end
      end

      ST_SLIP: begin
        state_n    = ST_WAIT;
        wait_cnt_n = '0;
      end

      ST_WAIT: begin
        if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
          state_n    = ST_COUNT;
          wait_cnt_n = '0;
        end else begin
          wait_cnt_n = wait_cnt + WAIT_W'(1);
        end
      end

      default: begin
        state_n = ST_COUNT;
      end
    endcase
  end

  assign rx.o_block_lock = block_lock;
  assign rx.o_slip       = slip;

endmodule

// File: tb/tb_rx_block_sync.sv
// Directed bench for rx_block_sync: lock, slip, tolerated errors, loss of lock,
// valid gaps and reset in mid-operation, with hand-computed expectations.
module tb_rx_block_sync;

  localparam int SLIP_WAIT = 8;

  logic clk = 1'b0;
  logic rst_n;

  rx_block_sync_if #(.HDR_WIDTH(2)) rx_if ();

  rx_block_sync #(
    .HDR_WIDTH      (2),
    .SH_CNT_MAX     (64),
    .SH_INVALID_MAX (16),
    .SLIP_WAIT      (SLIP_WAIT)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .rx        (rx_if.slave)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   v_cyc    = 0;
  int   slip_count = 0;
  int   s0;
  logic lock_v, slip_v, slip_i;
  logic seen, dropped;

  // Counts slip pulses independently of the directed checks.
  always @(negedge clk) if (rx_if.o_slip === 1'b1) slip_count++;

  task automatic applyStimulus(input logic [1:0] hdr, input logic vld);
    rx_if.i_rx_hdr       = hdr;
    rx_if.i_rx_hdr_valid = vld;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic hdr_pair(input logic [1:0] hdr);
    applyStimulus(hdr, 1'b1);
    lock_v = rx_if.o_block_lock;
    slip_v = rx_if.o_slip;
    v_cyc  = cyc;
    applyStimulus(hdr, 1'b0);
    slip_i = rx_if.o_slip;
  endtask

  task automatic run_valid(input int n);
    seen = 1'b0;
    repeat (n) begin
      hdr_pair(2'b01);
      if (lock_v !== 1'b0) seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    applyStimulus(2'b01, 1'b0);
    applyStimulus(2'b01, 1'b0);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(2'b01, 1'b1);
    n_checks++;
    if (rx_if.o_block_lock !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_lock: got %b expected 0", rx_if.o_block_lock); end
    n_checks++;
    if (rx_if.o_slip !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_slip: got %b expected 0", rx_if.o_slip); end
    rst_n = 1'b1;
  endtask

  task automatic test_lock_acquire();
    do_reset();
    s0 = slip_count;
    run_valid(63);
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL acquire_early: got lock before header 64"); end
    hdr_pair(2'b01);
    n_checks++;
    if (lock_v !== 1'b1) begin n_fail++; $display("[TB] FAIL acquire_lock: got %b expected 1", lock_v); end
    n_checks++;
    if (v_cyc != 127) begin n_fail++; $display("[TB] FAIL acquire_latency: got cycle %0d expected 127", v_cyc); end
    n_checks++;
    if (slip_count != s0) begin n_fail++; $display("[TB] FAIL acquire_noslip: got %0d slips expected 0", slip_count - s0); end
  endtask

  task automatic test_slip_unlocked();
    do_reset();
    s0 = slip_count;
    run_valid(40);
    applyStimulus(2'b11, 1'b1);
    n_checks++;
    if (rx_if.o_slip !== 1'b1) begin n_fail++; $display("[TB] FAIL unlocked_slip: got %b expected 1", rx_if.o_slip); end
    n_checks++;
    if (rx_if.o_block_lock !== 1'b0) begin n_fail++; $display("[TB] FAIL unlocked_lock: got %b expected 0", rx_if.o_block_lock); end
    applyStimulus(2'b00, 1'b1);
    n_checks++;
    if (rx_if.o_slip !== 1'b0) begin n_fail++; $display("[TB] FAIL slip_width: got %b expected 0", rx_if.o_slip); end
    repeat (SLIP_WAIT) applyStimulus(2'b00, 1'b1);
    n_checks++;
    if (slip_count != s0 + 1) begin n_fail++; $display("[TB] FAIL wait_ignores: got %0d slips expected 1", slip_count - s0); end
    run_valid(63);
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL relock_early: got lock before header 64"); end
    hdr_pair(2'b01);
    n_checks++;
    if (lock_v !== 1'b1) begin n_fail++; $display("[TB] FAIL relock: got %b expected 1", lock_v); end
    n_checks++;
    if (slip_count != s0 + 1) begin n_fail++; $display("[TB] FAIL relock_slips: got %0d slips expected 1", slip_count - s0); end
  endtask

  task automatic test_tolerate();
    logic bad;
    do_reset();
    run_valid(64);
    n_checks++;
    if (lock_v !== 1'b1) begin n_fail++; $display("[TB] FAIL tolerate_lock: got %b expected 1", lock_v); end
    s0 = slip_count;
    for (int w = 0; w < 3; w++) begin
      dropped = 1'b0;
      for (int p = 1; p <= 64; p++) begin
        if (w == 0)      bad = (p <= 15);
        else if (w == 1) bad = (p >= 50);
        else             bad = ((p % 4) == 0) && (p <= 60);
        hdr_pair(bad ? 2'b11 : 2'b01);
        if (lock_v !== 1'b1) dropped = 1'b1;
      end
      n_checks++;
      if (dropped !== 1'b0) begin n_fail++; $display("[TB] FAIL tolerate_window%0d: got lock drop expected none", w); end
    end
    n_checks++;
    if (slip_count != s0) begin n_fail++; $display("[TB] FAIL tolerate_noslip: got %0d slips expected 0", slip_count - s0); end
  endtask

  task automatic test_loss_of_lock();
    do_reset();
    run_valid(64);
    run_valid(10);
    repeat (15) hdr_pair(2'b11);
    n_checks++;
    if (lock_v !== 1'b1 || slip_v !== 1'b0) begin n_fail++; $display("[TB] FAIL loss_at15: got lock=%b slip=%b expected lock=1 slip=0", lock_v, slip_v); end
    hdr_pair(2'b11);
    n_checks++;
    if (lock_v !== 1'b0) begin n_fail++; $display("[TB] FAIL loss_lock: got %b expected 0", lock_v); end
    n_checks++;
    if (slip_v !== 1'b1) begin n_fail++; $display("[TB] FAIL loss_slip: got %b expected 1", slip_v); end
    n_checks++;
    if (slip_i !== 1'b0) begin n_fail++; $display("[TB] FAIL loss_slip_width: got %b expected 0", slip_i); end
    repeat (SLIP_WAIT) applyStimulus(2'b01, 1'b0);
    run_valid(63);
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL loss_relock_early: got lock before header 64"); end
    hdr_pair(2'b01);
    n_checks++;
    if (lock_v !== 1'b1) begin n_fail++; $display("[TB] FAIL loss_relock: got %b expected 1", lock_v); end
    run_valid(48);
    repeat (15) hdr_pair(2'b11);
    n_checks++;
    if (lock_v !== 1'b1) begin n_fail++; $display("[TB] FAIL pos63_lock: got %b expected 1", lock_v); end
    hdr_pair(2'b11);
    n_checks++;
    if (lock_v !== 1'b0 || slip_v !== 1'b1) begin n_fail++; $display("[TB] FAIL loss_at_pos64: got lock=%b slip=%b expected lock=0 slip=1", lock_v, slip_v); end
  endtask

  task automatic test_valid_gaps();
    do_reset();
    run_valid(32);
    repeat (20) applyStimulus(2'b11, 1'b0);
    run_valid(31);
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL gap_early: got lock before header 64"); end
    hdr_pair(2'b01);
    n_checks++;
    if (lock_v !== 1'b1) begin n_fail++; $display("[TB] FAIL gap_lock: got %b expected 1", lock_v); end
    n_checks++;
    if (v_cyc != 147) begin n_fail++; $display("[TB] FAIL gap_latency: got cycle %0d expected 147", v_cyc); end
  endtask

  task automatic test_reset_midway();
    do_reset();
    run_valid(64);
    run_valid(20);
    rst_n = 1'b0;
    applyStimulus(2'b01, 1'b1);
    n_checks++;
    if (rx_if.o_block_lock !== 1'b0 || rx_if.o_slip !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_locked: got lock=%b slip=%b expected 0 0", rx_if.o_block_lock, rx_if.o_slip); end
    rst_n = 1'b1;
    run_valid(63);
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_locked_early: got lock before header 64"); end
    hdr_pair(2'b01);
    n_checks++;
    if (lock_v !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_locked_relock: got %b expected 1", lock_v); end

    do_reset();
    applyStimulus(2'b00, 1'b1);
    n_checks++;
    if (rx_if.o_slip !== 1'b1) begin n_fail++; $display("[TB] FAIL wait_entry_slip: got %b expected 1", rx_if.o_slip); end
    repeat (4) applyStimulus(2'b01, 1'b0);
    s0 = slip_count;
    rst_n = 1'b0;
    applyStimulus(2'b01, 1'b0);
    n_checks++;
    if (rx_if.o_block_lock !== 1'b0 || rx_if.o_slip !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wait: got lock=%b slip=%b expected 0 0", rx_if.o_block_lock, rx_if.o_slip); end
    rst_n = 1'b1;
    run_valid(63);
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wait_early: got lock before header 64"); end
    hdr_pair(2'b01);
    n_checks++;
    if (lock_v !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_wait_relock: got %b expected 1", lock_v); end
    n_checks++;
    if (slip_count != s0) begin n_fail++; $display("[TB] FAIL reset_wait_noslip: got %0d slips expected 0", slip_count - s0); end
  endtask

  initial begin
    rst_n                = 1'b0;
    rx_if.i_rx_hdr       = 2'b01;
    rx_if.i_rx_hdr_valid = 1'b0;
    test_reset();
    test_lock_acquire();
    test_slip_unlocked();
    test_tolerate();
    test_loss_of_lock();
    test_valid_gaps();
    test_reset_midway();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
